// File: rtl/pixel_shift_sequencer.sv
// Four-position pixel-shift capture controller: steps the actuator through
// (0,0),(1,0),(0,1),(1,1), triggers one frame per position and emits
// interleaved high-resolution buffer writes at (2x+dx, 2y+dy).
module pixel_shift_sequencer #(
  parameter int unsigned INPUT_WIDTH   = 720,
  parameter int unsigned INPUT_HEIGHT  = 480,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned ACK_TIMEOUT   = 65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        shift_req,
  output logic        shift_x,
  output logic        shift_y,
  input  logic        shift_ack,
  output logic        capture_req,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        wr_en,
  output logic [10:0] wr_x,
  output logic [9:0]  wr_y,
  output logic [11:0] wr_data,
  output logic [1:0]  color_phase,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 9;
  localparam int unsigned PW      = 2;
  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_CAPTURE, S_NEXT, S_ERROR
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [PW-1:0]   phase;
  logic            accept, last_pix, restart, x_last, y_last;
  logic            shift_req_d, capture_req_d, busy_d, error_d, done_d, wr_en_d;

  assign x_last   = (x == XW'(INPUT_WIDTH - 1));
  assign y_last   = (y == YW'(INPUT_HEIGHT - 1));
  assign last_pix = x_last && y_last;
  assign accept   = (state == S_CAPTURE) && pix_valid && !abort;
  assign restart  = start && ((state == S_IDLE) || (state == S_ERROR));

  assign color_phase = phase;
  assign shift_x     = phase[0];
  assign shift_y     = phase[1];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; abort overrides everything
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) next_state = S_MOVE;
        S_MOVE: begin
          if (shift_ack)                         next_state = S_SETTLE;
          else if (cnt == CW'(ACK_TIMEOUT - 1))  next_state = S_ERROR;
        end
        S_SETTLE:  if (cnt == CW'(SETTLE_CYCLES - 1)) next_state = S_CAPTURE;
        S_CAPTURE: if (accept && last_pix) next_state = S_NEXT;
        S_NEXT:    next_state = (phase == PW'(3)) ? S_IDLE : S_MOVE;
        S_ERROR:   if (start) next_state = S_MOVE;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every strobe is registered
  always_comb begin
    shift_req_d   = 1'b0;
    capture_req_d = 1'b0;
    busy_d        = 1'b0;
    error_d       = 1'b0;
    done_d        = 1'b0;
    wr_en_d       = 1'b0;
    shift_req_d   = (next_state == S_MOVE);
    capture_req_d = (next_state == S_CAPTURE) && (state != S_CAPTURE);
    busy_d        = !((next_state == S_IDLE) || (next_state == S_ERROR));
    error_d       = (next_state == S_ERROR);
    done_d        = (state == S_NEXT) && (phase == PW'(3)) && !abort;
    wr_en_d       = accept;
  end

  // Output registers and buffer write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_req   <= 1'b0;
      capture_req <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      done        <= 1'b0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
    end else begin
      shift_req   <= shift_req_d;
      capture_req <= capture_req_d;
      busy        <= busy_d;
      error       <= error_d;
      done        <= done_d;
      wr_en       <= wr_en_d;
      if (accept) begin
        wr_x    <= {x, phase[0]};
        wr_y    <= {y, phase[1]};
        wr_data <= pix_data;
      end
    end
  end

  // Wait counter, pixel counters and phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      phase <= '0;
    end else if (abort) begin
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      phase <= '0;
    end else begin
      if (next_state != state)
        cnt <= '0;
      else if ((state == S_MOVE) || (state == S_SETTLE))
        cnt <= cnt + CW'(1);

      if (restart) begin
        x     <= '0;
        y     <= '0;
        phase <= '0;
      end else begin
        if (accept) begin
          if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        if ((state == S_NEXT) && (phase != PW'(3)))
          phase <= phase + PW'(1);
      end
    end
  end

endmodule
